mbus_timer: RTL and testbench
=============================

// Module: mbus_timer
// PURPOSE
//  Memory-bus responder: a countdown timer peripheral on the CPU's mbus. Decodes mbus_aout,
//  accepts mbus_wen writes, and drives read data back on the CPU's mbus_din input.
//  Reads are combinational; the CPU samples them in the same phase it drives the address.
//  Raises irq on underflow. Sits beside the memory on the same mbus, with read data OR-combined.
// PARAMETERS
//  WIDTH      32       data width; all timer registers are WIDTH bits
//  ADDR_SIZE  32       address width
//  BASE       32'hff00 base word address; low 4 bits must be 0
// PORTS
//  clk        in   1          clock; all state changes on posedge
//  reset      in   1          asynchronous, active-low reset
//  mbus_aout  in   ADDR_SIZE  word address from the CPU
//  mbus_dout  in   WIDTH      write data from the CPU
//  mbus_wen   in   1          write enable from the CPU
//  mbus_din   out  WIDTH      read data to the CPU; 0 when not selected
//  sel        out  1          address is inside this block's 16-word window
//  irq        out  1          OVF & IE
// BEHAVIOUR
//  Decode
//   - sel = (mbus_aout[ADDR_SIZE-1:4] == BASE[ADDR_SIZE-1:4]).
//   - off = mbus_aout[3:0].
//  Register map
//   - off0 CTRL: bit0 EN, bit1 AR (auto-reload), bit2 IE; other bits read 0.
//   - off1 RELOAD: R/W.
//   - off2 COUNT: read returns the live count; write loads the count.
//   - off3 STAT: bit0 OVF; write 1 to clear; other bits read 0.
//   - off4 PRESC: R/W.
//   - off5..15: read 0, writes ignored.
//  Read path
//   - mbus_din = sel ? reg[off] : 0. Combinational, zero latency.
//  Write path
//   - Register updates at posedge clk when sel & mbus_wen.
//   - Written value is visible on the read path in the next cycle.
//  Reset
//   - reset low clears CTRL, RELOAD, COUNT, OVF, PRESC and pcnt immediately, with no clock.
//   - Hence irq=0; mbus_din reads 0 at every offset.
//  Prescaler (pcnt, WIDTH bits)
//   - While EN=1: if pcnt==PRESC, then pcnt<=0 and tick=1 for that cycle; else pcnt<=pcnt+1.
//   - While EN=0: pcnt holds at 0.
//   - PRESC=0 gives a tick every clock.
//  Tick with COUNT!=0
//   - COUNT<=COUNT-1.
//  Tick with COUNT==0 (underflow)
//   - OVF<=1.
//   - AR=1: COUNT<=RELOAD; EN stays 1.
//   - AR=0: COUNT stays 0; EN<=0 (one-shot stop).
//  States
//   - IDLE (EN=0) -> RUN on a CTRL write with EN=1.
//   - RUN -> IDLE on a CTRL write with EN=0, or on a one-shot underflow.
//  Simultaneous events
//   - CPU write to COUNT in the same cycle as a tick: the write wins and the decrement is lost.
//   - CPU write to CTRL with EN=1 in the same cycle as a one-shot underflow: the written CTRL wins.
//   - STAT write-1-clear in the same cycle as an underflow: the set wins, OVF=1.
//   - Writing PRESC does not reset pcnt; if pcnt>new PRESC, pcnt wraps through 2^WIDTH-1 to 0.
//  Arithmetic
//   - Decrement never executes at 0, so COUNT never wraps.
//   - Counters are unsigned WIDTH-bit.
// TESTING
//  1. Release reset -> read off0..off4 all 0; irq=0; read with aout=BASE+16 -> mbus_din=0, sel=0.
//  2. PRESC=0, COUNT=3, CTRL=5 -> COUNT reads 2,1,0 on the next 3 clocks.
//     Next clock: OVF=1, irq=1, CTRL reads 4 (EN cleared); COUNT holds 0.
//  3. PRESC=2, RELOAD=1, COUNT=1, CTRL=3 -> COUNT 1 -> 0 after 3 clocks.
//     -> underflow at clock 6 reloads 1; OVF=1; irq stays 0 (IE=0).
//  4. Force an underflow and a STAT write 32'h1 in the same cycle -> OVF=1.
//     A write of 32'h1 on the next cycle -> OVF=0, irq=0.
//  5. Write 32'hdead to BASE+7 and to BASE+16 -> every register unchanged.
//     A COUNT write colliding with a tick -> COUNT equals the written value.
//  6. Assert reset mid-count with clk stopped -> COUNT, CTRL and OVF read 0 immediately; irq=0.

Source files
------------

// File: rtl/mbus_timer.sv
// Countdown timer peripheral on the CPU memory bus: 16-word register window,
// combinational read-back, prescaled countdown with optional auto-reload and underflow irq.
module mbus_timer #(
    parameter int unsigned              WIDTH     = 32,
    parameter int unsigned              ADDR_SIZE = 32,
    parameter logic [ADDR_SIZE-1:0]     BASE      = 'hff00
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ADDR_SIZE-1:0] mbus_aout,
    input  logic [WIDTH-1:0]     mbus_dout,
    input  logic                 mbus_wen,
    output logic [WIDTH-1:0]     mbus_din,
    output logic                 sel,
    output logic                 irq
);

    // The EN bit doubles as the run/idle state of the timer.
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam logic [3:0] OFF_CTRL   = 4'd0;
    localparam logic [3:0] OFF_RELOAD = 4'd1;
    localparam logic [3:0] OFF_COUNT  = 4'd2;
    localparam logic [3:0] OFF_STAT   = 4'd3;
    localparam logic [3:0] OFF_PRESC  = 4'd4;

    logic [2:0]       ctrl_reg,   ctrl_next;
    logic [WIDTH-1:0] reload_reg, reload_next;
    logic [WIDTH-1:0] count_reg,  count_next;
    logic             ovf_reg,    ovf_next;
    logic [WIDTH-1:0] presc_reg,  presc_next;
    logic [WIDTH-1:0] pcnt_reg,   pcnt_next;

    logic [3:0]       off;
    logic             wr;
    logic             running;
    logic             tick;
    logic             underflow;
    logic [WIDTH-1:0] rd_tbl [16];

    assign sel       = (mbus_aout[ADDR_SIZE-1:4] == BASE[ADDR_SIZE-1:4]);
    assign off       = mbus_aout[3:0];
    assign wr        = sel && mbus_wen;
    assign running   = (ctrl_reg[0] == RUN);
    assign tick      = running && (pcnt_reg == presc_reg);
    assign underflow = tick && (count_reg == '0);
    assign irq       = ovf_reg && ctrl_reg[2];

    assign rd_tbl[0] = {{(WIDTH-3){1'b0}}, ctrl_reg};
    assign rd_tbl[1] = reload_reg;
    assign rd_tbl[2] = count_reg;
    assign rd_tbl[3] = {{(WIDTH-1){1'b0}}, ovf_reg};
    assign rd_tbl[4] = presc_reg;

    generate
        for (genvar gi = 5; gi < 16; gi++) begin : g_unused_off
            assign rd_tbl[gi] = '0;
        end
    endgenerate

    assign mbus_din = sel ? rd_tbl[off] : '0;

    always_comb begin
        ctrl_next   = ctrl_reg;
        reload_next = reload_reg;
        count_next  = count_reg;
        ovf_next    = ovf_reg;
        presc_next  = presc_reg;
        pcnt_next   = '0;

        if (running) begin
            pcnt_next = (pcnt_reg == presc_reg) ? '0 : pcnt_reg + WIDTH'(1);
        end

        if (tick) begin
            if (count_reg != '0) begin
                count_next = count_reg - WIDTH'(1);
            end else if (ctrl_reg[1]) begin
                count_next = reload_reg;
            end else begin
                ctrl_next[0] = IDLE;
            end
        end

        // CPU writes override timer activity, except that an underflow beats a clear of OVF.
        if (wr) begin
            case (off)
                OFF_CTRL:   ctrl_next   = mbus_dout[2:0];
                OFF_RELOAD: reload_next = mbus_dout;
                OFF_COUNT:  count_next  = mbus_dout;
                OFF_STAT:   if (mbus_dout[0]) ovf_next = 1'b0;
                OFF_PRESC:  presc_next  = mbus_dout;
                default:    ;
            endcase
        end

        if (underflow) begin
            ovf_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_reg   <= '0;
            reload_reg <= '0;
            count_reg  <= '0;
            ovf_reg    <= 1'b0;
            presc_reg  <= '0;
            pcnt_reg   <= '0;
        end else begin
            ctrl_reg   <= ctrl_next;
            reload_reg <= reload_next;
            count_reg  <= count_next;
            ovf_reg    <= ovf_next;
            presc_reg  <= presc_next;
            pcnt_reg   <= pcnt_next;
        end
    end

endmodule

// File: tb/tb_mbus_timer.sv
// Directed table-driven bench for mbus_timer: bus reads/writes with hand-computed results.
module tb_mbus_timer;

    localparam logic [31:0] B   = 32'hff00;
    localparam logic [31:0] OUT = 32'hff10;

    logic        clk = 1'b0;
    logic        clk_run = 1'b1;
    logic        reset = 1'b0;
    logic [31:0] mbus_aout = '0;
    logic [31:0] mbus_dout = '0;
    logic        mbus_wen = 1'b0;
    logic [31:0] mbus_din;
    logic        sel;
    logic        irq;

    int total = 0;
    int passed = 0;

    typedef struct {
        logic [31:0] aout;
        logic [31:0] dout;
        logic        wen;
        logic [31:0] din;
        logic        sel;
        logic        irq;
    } vec_t;

    vec_t vecs[$];

    mbus_timer dut (
        .clk       (clk),
        .reset     (reset),
        .mbus_aout (mbus_aout),
        .mbus_dout (mbus_dout),
        .mbus_wen  (mbus_wen),
        .mbus_din  (mbus_din),
        .sel       (sel),
        .irq       (irq)
    );

    always #5 if (clk_run) clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic add(input logic [31:0] a, input logic [31:0] d, input logic w,
                       input logic [31:0] din, input logic s, input logic i);
        vec_t v;
        v.aout = a; v.dout = d; v.wen = w; v.din = din; v.sel = s; v.irq = i;
        vecs.push_back(v);
    endtask

    // Read: current value expected. Write: old value expected on the read path.
    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input logic i);
        add(a, 32'h0, 1'b0, exp, (a != OUT), i);
    endtask
    task automatic wrt(input logic [31:0] a, input logic [31:0] d, input logic [31:0] old, input logic i);
        add(a, d, 1'b1, old, (a != OUT), i);
    endtask

    initial begin
        // reset state
        rd(B+0, 0, 0); rd(B+1, 0, 0); rd(B+2, 0, 0); rd(B+3, 0, 0); rd(B+4, 0, 0);
        rd(OUT, 0, 0);
        // one-shot countdown, PRESC=0
        wrt(B+4, 0, 0, 0); wrt(B+2, 3, 0, 0); wrt(B+0, 5, 0, 0);
        rd(B+2, 3, 0); rd(B+2, 2, 0); rd(B+2, 1, 0); rd(B+2, 0, 0);
        rd(B+3, 1, 1); rd(B+0, 4, 1); rd(B+2, 0, 1);
        // auto-reload with PRESC=2
        wrt(B+3, 1, 1, 1); wrt(B+4, 2, 0, 0); wrt(B+1, 1, 0, 0); wrt(B+2, 1, 0, 0);
        wrt(B+0, 3, 4, 0);
        rd(B+2, 1, 0); rd(B+2, 1, 0); rd(B+2, 1, 0); rd(B+2, 0, 0); rd(B+2, 0, 0);
        rd(B+2, 0, 0); rd(B+2, 1, 0); rd(B+3, 1, 0);
        // STAT clear colliding with underflow: set wins
        rd(B+0, 3, 0); rd(B+2, 0, 0);
        wrt(B+3, 1, 1, 0); wrt(B+3, 1, 0, 0); wrt(B+3, 1, 1, 0); rd(B+3, 0, 0);
        // stop, then writes to unmapped offset / outside window
        wrt(B+0, 0, 3, 0);
        wrt(B+7, 32'hdead, 0, 0); wrt(OUT, 32'hdead, 0, 0);
        rd(B+0, 0, 0); rd(B+1, 1, 0); rd(B+2, 0, 0); rd(B+3, 0, 0); rd(B+4, 2, 0);
        rd(B+7, 0, 0);
        // COUNT write colliding with a tick: write wins
        wrt(B+4, 0, 2, 0); wrt(B+2, 5, 0, 0); wrt(B+0, 1, 0, 0);
        rd(B+2, 5, 0); wrt(B+2, 9, 4, 0); rd(B+2, 9, 0); rd(B+2, 8, 0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        foreach (vecs[k]) begin
            @(posedge clk);
            #1;
            mbus_aout = vecs[k].aout;
            mbus_dout = vecs[k].dout;
            mbus_wen  = vecs[k].wen;
            #3;
            check($sformatf("v%0d din @%0h", k, vecs[k].aout), mbus_din, vecs[k].din);
            check($sformatf("v%0d sel", k), {31'b0, sel}, {31'b0, vecs[k].sel});
            check($sformatf("v%0d irq", k), {31'b0, irq}, {31'b0, vecs[k].irq});
            $display("vec %0d aout=%0h wen=%0b dout=%0h din=%0h sel=%0b irq=%0b",
                     k, mbus_aout, mbus_wen, mbus_dout, mbus_din, sel, irq);
        end

        // one-shot underflow with IE set raises irq, then reset with the clock stopped
        @(posedge clk); #1;
        mbus_aout = B+2; mbus_dout = 2; mbus_wen = 1'b1;
        @(posedge clk); #1;
        mbus_aout = B+0; mbus_dout = 5;
        @(posedge clk); #1;
        mbus_wen = 1'b0; mbus_aout = B+2;
        repeat (3) @(posedge clk);
        #1;
        check("pre-reset irq", {31'b0, irq}, 32'd1);
        @(posedge clk); #1;
        mbus_wen = 1'b1; mbus_aout = B+2; mbus_dout = 7;
        @(posedge clk); #1;
        mbus_aout = B+0; mbus_dout = 1;
        @(posedge clk); #1;
        mbus_wen = 1'b0; mbus_aout = B+2;
        @(posedge clk);
        @(negedge clk);
        clk_run = 1'b0;
        #1;
        check("pre-reset count", mbus_din, 32'd6);
        reset = 1'b0;
        #1;
        check("reset count", mbus_din, 32'd0);
        mbus_aout = B+0; #1;
        check("reset ctrl", mbus_din, 32'd0);
        mbus_aout = B+3; #1;
        check("reset stat", mbus_din, 32'd0);
        check("reset irq", {31'b0, irq}, 32'd0);
        $display("reset with clock stopped: din=%0h irq=%0b", mbus_din, irq);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
